// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
package seg7_pkg;

  // Two phases of every digit slot: guard time with everything off, then drive.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Active-low segment pattern with every segment dark.
  localparam logic [6:0] SEG_OFF_N = 7'b1111111;

  // Digit count used when the instantiating design does not override it.
  localparam int DEFAULT_NUM_DIGITS = 4;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-high seven-segment pattern, order abcdefg (bit 6 = a).
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure decode table; lower-case b and d keep 8/B and 0/D distinguishable.
  always_comb begin
    seg = 7'b0000000;
    case (nibble)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: per-digit BLANK/DRIVE slots, frame-
// synchronous display update with a pending buffer, optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int BLANK_CYCLES = 1000,
  parameter int DRIVE_CYCLES = 99000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int CNT_MAX = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Refuse to build with slot lengths the counter/boundary logic cannot honour.
  generate
    if (BLANK_CYCLES < 1 || DRIVE_CYCLES < 2 || NUM_DIGITS < 1) begin : g_bad_params
      $error("seg7_scan_driver: need BLANK_CYCLES>=1, DRIVE_CYCLES>=2, NUM_DIGITS>=1");
    end
  endgenerate

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_done_q, frame_done_d;

  logic                    boundary;
  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic                    lz_sel;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   nib_zero;
  logic [NUM_DIGITS-1:0]   lz_blankable;

  // A digit may be blanked only if it and every more-significant nibble is zero;
  // digit 0 always shows so a zero value still displays "0".
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign nib_zero[gi] = (disp_val_q[4*gi +: 4] == 4'h0);
      if (gi == 0) begin : g_lsd
        assign lz_blankable[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blankable[gi] = &nib_zero[NUM_DIGITS-1:gi];
      end
    end
  endgenerate

  // Select the nibble, decimal point and blanking flag of the digit in its slot.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    lz_sel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel = disp_val_q[4*i +: 4];
        dp_sel  = disp_dp_q[i];
        lz_sel  = lz_blankable[i];
      end
    end
  end

  hex_to_7seg u_hex (
    .nibble (nib_sel),
    .seg    (seg_raw)
  );

  // Next-state, display-buffer and output computation for the current slot cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CNT_W'(1);
    boundary     = 1'b0;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    an_n_d       = '1;
    seg_n_d      = SEG_OFF_N;
    dp_n_d       = 1'b1;

    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        an_n_d = ~(NUM_DIGITS'(1) << idx_q);
        if (!(blank_lz && lz_sel)) begin
          seg_n_d = ~seg_raw;
          dp_n_d  = ~dp_sel;
        end
        if (cnt_q == DRIVE_LAST) begin
          state_d  = BLANK;
          cnt_d    = '0;
          boundary = (idx_q == IDX_LAST);
          idx_d    = boundary ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase

    // A load on the boundary cycle is newest and goes straight to the display.
    if (boundary) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end

    frame_done_d = boundary;
  end

  // All state and outputs share one edge so anodes and segments stay paired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      an_n_q       <= '1;
      seg_n_q      <= SEG_OFF_N;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits.
REQ-002 Parameter BLANK_CYCLES, default 1000: all-off guard cycles before each digit is driven.
REQ-003 Parameter DRIVE_CYCLES, default 99000: cycles each digit is driven.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load  input  1  one-cycle strobe; capture value and dp_in.
REQ-007 value  input  4*NUM_DIGITS  hex value; digit 0 = value[3:0], rightmost.
REQ-008 dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-009 blank_lz  input  1  level; 1 = suppress leading zeros.
REQ-010 an_n  output  NUM_DIGITS  active-low digit anodes; bit i drives digit i.
REQ-011 seg_n  output  7  active-low segments, order abcdefg (bit 6 = a).
REQ-012 dp_n  output  1  active-low decimal point.
REQ-013 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-014 Two-state FSM per digit slot: BLANK (BLANK_CYCLES cycles) then DRIVE (DRIVE_CYCLES cycles), then next digit in BLANK.
REQ-015 Digit index advances 0,1,...,NUM_DIGITS-1 and wraps to 0; each slot lasts BLANK_CYCLES+DRIVE_CYCLES cycles.
REQ-016 In BLANK: an_n all ones, seg_n = 7'b1111111, dp_n = 1.
REQ-017 In DRIVE of digit i: an_n has only bit i low; seg_n is the bitwise inverse of the hex decode of display nibble i; dp_n = ~dp register bit i.
REQ-018 an_n, seg_n and dp_n are registered; no combinational path from any input to any output.
REQ-019 Output registers change on the same edge as the FSM state and index, so a digit's anode and its segments are never mismatched.
REQ-020 load captures value and dp_in into a pending register and sets a pending flag; a later load in the same frame overwrites it (last wins).
REQ-021 At the frame boundary (last DRIVE cycle of digit NUM_DIGITS-1), pending contents move to the display register and the flag clears; the display never changes mid-frame.
REQ-022 load asserted on the boundary cycle itself bypasses pending and its value is displayed from the next frame.
REQ-023 With blank_lz=1, digit i>=1 is forced to seg_n all ones and dp_n=1 when display nibbles i..NUM_DIGITS-1 are all zero; its anode is still driven; digit 0 is never blanked.
REQ-024 blank_lz is sampled each DRIVE cycle; a change takes effect on the next output update.
REQ-025 frame_done pulses high for exactly the one cycle after the boundary cycle.
REQ-026 Slot cycle counter is sized clog2(max(BLANK_CYCLES,DRIVE_CYCLES)) bits; BLANK_CYCLES >= 1 and DRIVE_CYCLES >= 2 are required.
REQ-027 Violating those bounds is an elaboration-time error.

Reset
REQ-028 rst_n low forces an_n all ones, seg_n all ones, dp_n=1 and frame_done=0 immediately, independent of clk.
REQ-029 rst_n low clears the display, pending and dp registers and the pending flag, and sets index 0, state BLANK and counter 0.
REQ-030 After rst_n rises, the first rising edge begins BLANK of digit 0; reset mid-frame discards any pending load.

Structure
REQ-031 Shared package seg7_pkg holds the FSM state enum {BLANK, DRIVE}, the constant SEG_OFF_N = 7'b1111111 and the default NUM_DIGITS.
REQ-032 Instantiate exactly one hex_to_7seg on the mux-selected nibble and invert its output in this block.

Verification
REQ-033 Bench parameters: BLANK_CYCLES=2, DRIVE_CYCLES=4, NUM_DIGITS=4 (24-cycle frame).
REQ-034 Reset release, no load: digit 0 drives with an_n=1110 and seg_n=0000001 ("0") for 4 cycles after 2 blank cycles; frame_done every 24 cycles.
REQ-035 load value=16'h1A3F, dp_in=0100, mid-frame: current frame unchanged; next frame shows digit0 seg_n=0111000 (F), digit1 0000110 (3), digit2 0001000 (A) with dp_n=0, digit3 1001111 (1).
REQ-036 blank_lz=1, value=16'h0050: digits 3 and 2 give seg_n=1111111 with their anodes low; digit1=0100100 (5); digit0=0000001 (0).
REQ-037 Two loads in one frame (16'h1111 then 16'h2222), plus a load 16'h3333 on the boundary cycle: 16'h3333 shows next frame and 16'h2222 never appears.
REQ-038 rst_n pulsed low mid-DRIVE of digit 2 between clock edges: outputs go all-off before the next edge; the pending load is lost; scan restarts at digit 0 BLANK.
